// File: rtl/edge_pixel_fetch.sv
// edge_pixel_fetch: OBI read-DMA front end for the edge accelerator.
// Fetches len words from base and streams them out through a small FIFO.
module edge_pixel_fetch #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1,
  parameter int FifoDepth = 4,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 mgr_req_o,
  output logic [AddrWidth-1:0] mgr_addr_o,
  output logic                 mgr_we_o,
  output logic [3:0]           mgr_be_o,
  output logic [DataWidth-1:0] mgr_wdata_o,
  output logic [IdWidth-1:0]   mgr_id_o,
  input  logic                 mgr_gnt_i,
  input  logic                 mgr_rvalid_i,
  input  logic [DataWidth-1:0] mgr_rdata_i,
  input  logic [IdWidth-1:0]   mgr_rid_i,
  input  logic                 mgr_err_i,
  output logic                 px_valid_o,
  output logic [DataWidth-1:0] px_data_o,
  input  logic                 px_ready_i
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth) + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  len_q;
  logic [LenWidth-1:0]  issued_q;
  logic [LenWidth-1:0]  rcvd_q;
  logic [CntW-1:0]      outst_q;
  logic [CntW-1:0]      cnt_q;
  logic [CntW-1:0]      credits;
  logic [PtrW-1:0]      wptr_q;
  logic [PtrW-1:0]      rptr_q;
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic                 err_q;
  logic                 zl_done_q;

  logic active;
  logic accept;
  logic req;
  logic fire;
  logic push;
  logic pop;
  logic fin;
  logic unused_in;

  assign unused_in = ^{mgr_rid_i, base_addr_i[1:0]};

  assign active  = (state_q != IDLE);
  assign accept  = (state_q == IDLE) && start_i
                && (len_i != '0);
  assign credits = CntW'(FifoDepth) - outst_q - cnt_q;
  assign req     = (state_q == FETCH)
                && (issued_q < len_q)
                && (credits != '0);
  assign fire    = req && mgr_gnt_i;
  // Responses that arrive while idle belong to an aborted transfer.
  assign push    = mgr_rvalid_i && active;
  assign pop     = px_valid_o && px_ready_i;
  assign fin     = (state_q == DRAIN)
                && (rcvd_q == len_q)
                && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        if (fire && (issued_q + LenWidth'(1)) == len_q)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      rcvd_q    <= '0;
      err_q     <= 1'b0;
      zl_done_q <= 1'b0;
    end else begin
      zl_done_q <= (state_q == IDLE) && start_i
                && (len_i == '0);
      if (accept) begin
        addr_q   <= {base_addr_i[AddrWidth-1:2], 2'b00};
        len_q    <= len_i;
        issued_q <= '0;
        rcvd_q   <= '0;
        err_q    <= 1'b0;
      end else begin
        if (fire) begin
          issued_q <= issued_q + LenWidth'(1);
          addr_q   <= addr_q + AddrWidth'(4);
        end
        if (push) begin
          rcvd_q <= rcvd_q + LenWidth'(1);
          if (mgr_err_i) err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
    end else if (accept) begin
      outst_q <= '0;
    end else begin
      unique case (1'b1)
        fire && !push: outst_q <= outst_q + CntW'(1);
        push && !fire: outst_q <= outst_q - CntW'(1);
        default:       outst_q <= outst_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FifoDepth; i++)
        mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= mgr_rdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + CntW'(1);
        pop && !push: cnt_q <= cnt_q - CntW'(1);
        default:      cnt_q <= cnt_q;
      endcase
    end
  end

  assign busy_o      = active && !fin;
  assign done_o      = fin || zl_done_q;
  assign err_o       = err_q;
  assign mgr_req_o   = req;
  assign mgr_addr_o  = addr_q;
  assign mgr_we_o    = 1'b0;
  assign mgr_be_o    = 4'hF;
  assign mgr_wdata_o = '0;
  assign mgr_id_o    = '0;
  assign px_valid_o  = (cnt_q != '0);
  assign px_data_o   = mem_q[rptr_q];

endmodule

// File: tb/tb_edge_pixel_fetch.sv
// tb_edge_pixel_fetch: directed bench for edge_pixel_fetch.
// OBI responder answers one cycle after each grant.
module tb_edge_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [0:0]  id;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [0:0]  rid;
  logic        rerr;
  logic        px_valid;
  logic [31:0] px_data;
  logic        px_ready;

  always #5 clk = ~clk;

  edge_pixel_fetch dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .mgr_req_o    (req),
    .mgr_addr_o   (addr),
    .mgr_we_o     (we),
    .mgr_be_o     (be),
    .mgr_wdata_o  (wdata),
    .mgr_id_o     (id),
    .mgr_gnt_i    (gnt),
    .mgr_rvalid_i (rvalid),
    .mgr_rdata_i  (rdata),
    .mgr_rid_i    (rid),
    .mgr_err_i    (rerr),
    .px_valid_o   (px_valid),
    .px_data_o    (px_data),
    .px_ready_i   (px_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0;
  logic [31:0] addr_q [$];
  logic [31:0] got_q [$];
  int gcount, done_cnt, done_cyc, last_pop_cyc;
  int first_gnt_cyc, last_gnt_cyc;
  int stall_word, stall_left, err_word;

  logic        pend, pend_err;
  logic [31:0] pend_data;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] a);
    return a ^ 32'hC3C3_3C3C;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder and monitor share one process so ordering is fixed.
  initial begin
    pend = 0; pend_err = 0; pend_data = 0;
    prev_req = 0; prev_gnt = 1; prev_addr = 0;
    rvalid = 0; rdata = 0; rerr = 0; gnt = 1; rid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rvalid = 0; rdata = 0; rerr = 0; gnt = 1;
        pend = 0; prev_req = 0; prev_gnt = 1;
      end else begin
        rvalid = pend;
        rdata  = pend ? pend_data : 32'h0;
        rerr   = pend && pend_err;
        if (rvalid)
          chk("no_push_full", 32'(dut.cnt_q == 3'd4), 0);
        if (px_valid && px_ready) begin
          got_q.push_back(px_data);
          last_pop_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (prev_req && !prev_gnt) begin
          chk("req_hold", 32'(req), 1);
          chk("addr_hold", addr, prev_addr);
        end
        if (req && gcount == stall_word && stall_left > 0) begin
          gnt = 0;
          stall_left--;
        end else begin
          gnt = 1;
        end
        pend = req && gnt;
        if (pend) begin
          addr_q.push_back(addr);
          pend_data = pix(addr);
          pend_err  = (gcount == err_word);
          if (gcount == 0) first_gnt_cyc = cyc;
          last_gnt_cyc = cyc;
          gcount++;
        end
        prev_req  = req;
        prev_gnt  = gnt;
        prev_addr = addr;
      end
    end
  end

  task automatic do_start(input logic [31:0] b,
                          input logic [15:0] l,
                          input int sw, input int ew);
    addr_q.delete();
    got_q.delete();
    gcount = 0; done_cnt = 0;
    stall_word = sw; stall_left = 3; err_word = ew;
    @(posedge clk); #1;
    chk("req_idle", 32'(req), 0);
    start = 1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 0;
    chk("busy_start", 32'(busy), 1);
    chk("err_cleared", 32'(err), 0);
    chk("req_latency", 32'(req), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++)
      @(posedge clk);
    chk("done_timeout", 32'(done_cnt != 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_words(input logic [31:0] b,
                             input int l);
    logic [31:0] ab;
    ab = {b[31:2], 2'b00};
    chk("grant_cnt", 32'(gcount), 32'(l));
    chk("word_cnt", 32'(got_q.size()), 32'(l));
    for (int i = 0; i < l && i < got_q.size(); i++)
      chk("word_data", got_q[i], pix(ab + 32'(4 * i)));
    chk("done_once", 32'(done_cnt), 1);
    chk("done_after_pop", 32'(done_cyc),
        32'(last_pop_cyc + 1));
    chk("busy_end", 32'(busy), 0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          stall;
    int          errw;
    logic [31:0] first;
    logic [31:0] last;
    logic        exp_err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{32'h1000_0000, 16'd4, -1, -1,
               32'h1000_0000, 32'h1000_000C, 1'b0};
    tbl[1] = '{32'h2000_0013, 16'd3, 1, -1,
               32'h2000_0010, 32'h2000_0018, 1'b0};
    tbl[2] = '{32'hFFFF_FFFC, 16'd2, -1, 0,
               32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    tbl[3] = '{32'h0000_0040, 16'd1, -1, -1,
               32'h0000_0040, 32'h0000_0040, 1'b0};

    stall_word = -1; stall_left = 0; err_word = -1;
    gcount = 0; done_cnt = 0; done_cyc = 0;
    last_pop_cyc = 0; first_gnt_cyc = 0; last_gnt_cyc = 0;
    rst_n = 0; start = 0; base_addr = 0; len = 0;
    px_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", 32'(px_valid), 0);
    chk("rst_data", px_data, 0);
    rst_n = 1;

    for (int v = 0; v < 4; v++) begin
      do_start(tbl[v].base, tbl[v].len,
               tbl[v].stall, tbl[v].errw);
      wait_done();
      check_words(tbl[v].base, int'(tbl[v].len));
      if (addr_q.size() > 0) begin
        chk("first_addr", addr_q[0], tbl[v].first);
        chk("last_addr", addr_q[$], tbl[v].last);
      end
      chk("err_flag", 32'(err), 32'(tbl[v].exp_err));
      if (tbl[v].stall < 0)
        chk("throughput", 32'(last_gnt_cyc - first_gnt_cyc),
            32'(tbl[v].len - 16'd1));
    end

    // zero length
    gcount = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1; len = 0; base_addr = 32'h1234_0000;
    chk("zl_done_pre", 32'(done), 0);
    @(posedge clk); #1;
    start = 0;
    chk("zl_done", 32'(done), 1);
    chk("zl_busy", 32'(busy), 0);
    chk("zl_req", 32'(req), 0);
    @(posedge clk); #1;
    chk("zl_done_off", 32'(done), 0);
    chk("zl_busy2", 32'(busy), 0);
    chk("zl_grants", 32'(gcount), 0);

    // backpressure
    px_ready = 0;
    do_start(32'h3000_0000, 16'd8, -1, -1);
    repeat (12) @(posedge clk);
    #1;
    chk("bp_grants", 32'(gcount), 4);
    chk("bp_req", 32'(req), 0);
    chk("bp_valid", 32'(px_valid), 1);
    px_ready = 1;
    wait_done();
    check_words(32'h3000_0000, 8);

    // reset mid-transfer
    do_start(32'h4000_0000, 16'd6, -1, -1);
    for (int i = 0; i < 50 && got_q.size() < 2; i++)
      @(posedge clk);
    chk("mid_words", 32'(got_q.size() >= 2), 1);
    #1;
    rst_n = 0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_req", 32'(req), 0);
    chk("mr_addr", addr, 0);
    chk("mr_valid", 32'(px_valid), 0);
    chk("mr_data", px_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    do_start(32'h5000_0000, 16'd3, -1, -1);
    wait_done();
    check_words(32'h5000_0000, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_pixel_fetch.md
# edge_pixel_fetch

Read-DMA front end for the edge accelerator in the user domain. Given a base address and a word count, it issues word reads to SRAM over an OBI manager port and buffers the responses in a small FIFO. It presents the returned words, each holding four 8-bit pixels, in order as a valid/ready stream to the edge compute datapath. Its OBI manager port is the one the user domain forwards to the Croc crossbar.

## Interface

- AddrWidth, 32, OBI address width
- DataWidth, 32, OBI data width; one word = 4 pixels
- IdWidth, 1, OBI id width
- FifoDepth, 4, response buffer depth; power of two, >= 2
- LenWidth, 16, width of the word-count field

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse, sampled only in IDLE
- base_addr_i  in  AddrWidth  start byte address; bits [1:0] ignored (treated as 0)
- len_i  in  LenWidth  number of words to fetch
- busy_o  out  1  high from the accepted start until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky OBI error flag; cleared by the next accepted start
- mgr_req_o  out  1  OBI request
- mgr_addr_o  out  AddrWidth  OBI address
- mgr_we_o  out  1  constant 0
- mgr_be_o  out  4  constant 4'hF
- mgr_wdata_o  out  DataWidth  constant 0
- mgr_id_o  out  IdWidth  constant 0
- mgr_gnt_i  in  1  OBI grant
- mgr_rvalid_i  in  1  OBI response valid
- mgr_rdata_i  in  DataWidth  OBI read data
- mgr_rid_i  in  IdWidth  response id; ignored
- mgr_err_i  in  1  OBI response error
- px_valid_o  out  1  stream valid; equals FIFO not-empty
- px_data_o  out  DataWidth  stream data; equals FIFO head
- px_ready_i  in  1  stream ready

## Operation

- FSM states: IDLE, FETCH, DRAIN.
- IDLE, start_i=1, len_i>0:
  - latch addr = {base_addr_i[AddrWidth-1:2], 2'b00} and len = len_i
  - clear err_o and the issue/receive counters
  - go to FETCH
- IDLE, start_i=1, len_i=0: no request is issued; done_o pulses the next cycle and the FSM stays in IDLE.
- start_i is ignored while busy_o=1.
- FETCH:
  - mgr_req_o = (issued < len) && (credits > 0)
  - credits = FifoDepth − (outstanding + fifo_count)
  - On req && gnt: issued++, addr += 4 (mod 2^AddrWidth), outstanding++.
  - When issued == len, go to DRAIN.
- OBI stability: once mgr_req_o is high, mgr_req_o and mgr_addr_o stay unchanged until mgr_gnt_i.
- Every mgr_rvalid_i pushes mgr_rdata_i into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO never overflows. The bench must assert no push occurs while the FIFO is full.
- If mgr_err_i=1 with rvalid: set err_o. The data is still pushed, so the word count is preserved.
- Stream pop on px_valid_o && px_ready_i.
  - A simultaneous push and pop in the same cycle is legal and leaves the count unchanged.
- The outstanding counter handles a grant and an rvalid in the same cycle (net 0).
- DRAIN: when received == len and the FIFO is empty, done_o pulses, busy_o drops, and the FSM returns to IDLE.
- Reset (any time, including mid-transfer) returns the FSM to IDLE and empties the FIFO. All counters clear. In-flight OBI responses arriving after reset are dropped.

## Timing

- Reset values: busy_o=0, done_o=0, err_o=0, mgr_req_o=0, mgr_addr_o=0, px_valid_o=0, px_data_o=0.
- Latency to first request: mgr_req_o first rises the cycle after the accepted start_i.
- Throughput: 1 request/cycle with gnt=1 every cycle, rvalid one cycle after gnt, and px_ready_i=1.
- Stream latency: px_valid_o rises the cycle after the rvalid that fills an empty FIFO (registered FIFO, no bypass).
- done_o: high exactly one cycle, the cycle after the final pop; busy_o is low from that same cycle.
- Counters are LenWidth wide. The maximum transfer is 2^LenWidth−1 words.
- Address arithmetic: wraps modulo 2^AddrWidth, with no error.
- The outstanding count never exceeds FifoDepth.

## Test plan

- Basic fetch: base 0x1000_0000, len 4, gnt=1, rvalid one cycle after gnt, ready=1 → addresses 0x1000_0000/04/08/0C; data out in order; one done_o pulse; err_o=0.
- Zero length: len 0 → mgr_req_o stays 0; done_o pulses the cycle after start; busy_o never rises.
- Backpressure: len 8, FifoDepth 4, ready=0 → exactly 4 grants and then mgr_req_o=0. Release ready → remaining 4 issued; 8 words delivered in order with none lost.
- Grant stall: gnt withheld 3 cycles on word 1 → mgr_req_o and mgr_addr_o held stable for those cycles; transfer then completes correctly.
- Error and wrap: base 0xFFFF_FFFC, len 2, err_i on the first response → addresses 0xFFFF_FFFC then 0x0000_0000; both words delivered; err_o=1 after done. A new start clears err_o.
- Reset mid-transfer: assert rst_ni low after 2 of 6 words → all outputs at reset values. A new start with len 3 completes normally with exactly 3 words.
